dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/rr_arb2.sv | 36 +++
 rtl/dmem_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : access-size codes, FSM states and command type for dmem_arbiter
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] CTRL_WORD   = 3'b000;
    localparam logic [2:0] CTRL_BYTE_S = 3'b001;
    localparam logic [2:0] CTRL_HALF_S = 3'b010;
    localparam logic [2:0] CTRL_BYTE_U = 3'b100;
    localparam logic [2:0] CTRL_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // Unsigned sizes are load-only; anything off its natural boundary is rejected.
    function automatic logic cmd_err(input cmd_t c);
        logic e;
        e = 1'b0;
        case (c.ctrl)
            CTRL_WORD:   e = (c.addr[1:0] != 2'b00);
            CTRL_BYTE_S: e = 1'b0;
            CTRL_HALF_S: e = c.addr[0];
            CTRL_BYTE_U: e = c.we;
            CTRL_HALF_U: e = c.we | c.addr[0];
            default:     e = 1'b1;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// dmem_arbiter_if : two-port request/response bundle for dmem_arbiter
// Revision        : 1.0
// ============================================================================
interface dmem_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [2:0]  req_ctrl0;
    logic [2:0]  req_ctrl1;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_ctrl0, req_ctrl1,
               req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_ctrl0, req_ctrl1,
               req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2  : 2-way round-robin arbiter, one-hot grant, pointer moves on update
// Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] req,
    input  wire logic       update,
    output logic      [1:0] grant
);

    // High when port 1 holds the most recent grant; reset value lets port 0 win first.
    logic r_last;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (update) begin
            r_last <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-port round-robin front end to a single data memory
// Revision     : 1.0
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    dmem_arbiter_if.slave    bus,
    output logic             DMWr,
    output logic [2:0]       DMCtrl,
    output logic [31:0]      Address,
    output logic [31:0]      DataWr,
    input  wire logic [31:0] DataRd
);

    state_t      r_state;
    cmd_t        r_cmd;
    logic        r_err;
    logic        r_dmwr;
    logic [1:0]  r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_open;
    logic [1:0]  w_grant;
    logic        w_fire;
    cmd_t        w_cmd;
    logic        w_err;

    assign w_open = (r_state == ST_IDLE) || (r_state == ST_RESP);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req_valid & {2{w_open}}),
        .update (w_fire),
        .grant  (w_grant)
    );

    assign w_fire        = |w_grant;
    assign bus.req_ready = w_grant;

    always_comb begin
        w_cmd.port  = w_grant[1];
        w_cmd.we    = w_grant[1] ? bus.req_we[1]    : bus.req_we[0];
        w_cmd.ctrl  = w_grant[1] ? bus.req_ctrl1    : bus.req_ctrl0;
        w_cmd.addr  = w_grant[1] ? bus.req_addr1    : bus.req_addr0;
        w_cmd.wdata = w_grant[1] ? bus.req_wdata1   : bus.req_wdata0;
    end

    assign w_err = cmd_err(w_cmd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_err       <= 1'b0;
            r_dmwr      <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_dmwr      <= 1'b0;
            r_rsp_valid <= 2'b00;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_fire) begin
                        r_cmd   <= w_cmd;
                        r_err   <= w_err;
                        r_dmwr  <= w_cmd.we & ~w_err;
                        r_state <= ST_ACCESS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_rsp_valid <= r_cmd.port ? 2'b10 : 2'b01;
                    r_rsp_err   <= r_err;
                    r_rsp_rdata <= (r_err | r_cmd.we) ? '0 : DataRd;
                    r_state     <= ST_RESP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory-side outputs track the registered command so they hold between accesses.
    assign DMWr          = r_dmwr;
    assign Address       = r_cmd.addr;
    assign DMCtrl        = r_cmd.ctrl;
    assign DataWr        = r_cmd.wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
